id_ex_ctrl_stage: RTL

//   ID/EX pipeline register for the decoded control bundle from the instruction decoder, plus rd.

---
 rtl/id_ex_ctrl_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX pipeline register for the decoded control bundle and rd.
// Inserts a one-cycle bubble on load-use hazards, applies EX-stage flushes,
// and runs the ecall halt sequence: stop fetch, drain EX/MEM/WB, then
// assert is_halted.
module id_ex_ctrl_stage #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic                  id_mem_read,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_write_en,
  input  logic                  id_pc_to_reg,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_is_ecall,
  input  logic                  id_halt_cond,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_flush,
  output logic                  ex_mem_read,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_write_en,
  output logic                  ex_pc_to_reg,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_is_ecall,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_valid,
  output logic                  stall_if_id,
  output logic                  is_halted
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lu;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    lu = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
         ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Hold fetch during a load-use stall (unless flushed) and for the whole halt sequence.
  always_comb begin
    stall_if_id = 1'b0;
    if (state != RUN) stall_if_id = 1'b1;
    else              stall_if_id = lu & ~ex_flush;
  end

  // Pipeline register plus halt state machine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_write_en   <= 1'b0;
      ex_pc_to_reg  <= 1'b0;
      ex_alu_op     <= '0;
      ex_is_ecall   <= 1'b0;
      ex_rd         <= '0;
      ex_valid      <= 1'b0;
      state         <= RUN;
      cnt           <= '0;
      is_halted     <= 1'b0;
    end else begin
      // Bubble by default; only a clean RUN capture of a valid instruction overrides it.
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_write_en   <= 1'b0;
      ex_pc_to_reg  <= 1'b0;
      ex_alu_op     <= '0;
      ex_is_ecall   <= 1'b0;
      ex_rd         <= '0;
      ex_valid      <= 1'b0;
      case (state)
        RUN: begin
          if (!ex_flush && !lu && id_valid) begin
            ex_mem_read   <= id_mem_read;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_mem_write  <= id_mem_write;
            ex_alu_src    <= id_alu_src;
            ex_write_en   <= id_write_en;
            ex_pc_to_reg  <= id_pc_to_reg;
            ex_alu_op     <= id_alu_op;
            ex_is_ecall   <= id_is_ecall;
            ex_rd         <= id_rd;
            ex_valid      <= 1'b1;
            if (id_is_ecall && id_halt_cond) begin
              state <= DRAIN;
              cnt   <= CNT_W'(DRAIN_CYCLES - 1);
            end
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state     <= HALTED;
            is_halted <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HALTED: begin
          is_halted <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
